skid_buffer: RTL and testbench
==============================

Name: skid_buffer

Overview:
- Registered two-entry valid/ready pipeline stage that sits directly upstream of the bitwise inverter.
- m_data drives the inverter's data_in.
- Breaks all combinational paths between producer and consumer: data, valid and ready are all registered.
- Sustains full throughput of one word per clock.

Parameters:
DATA_WIDTH, 32, width in bits of the data path (s_data, m_data, internal registers); must be >= 1

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
s_valid  input  1  upstream word on s_data is valid
s_ready  output  1  block can accept a word this cycle (registered)
s_data  input  DATA_WIDTH  upstream data
m_valid  output  1  m_data holds a valid word (registered)
m_ready  input  1  downstream accepts m_data this cycle
m_data  output  DATA_WIDTH  output data (registered), feeds inverter data_in
level  output  2  occupancy: 0, 1 or 2 words held (registered)

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). Assertion takes effect immediately, regardless of clk.
- Reset values:
  - m_valid=0, s_ready=0, m_data=0, skid register=0, level=0, state=EMPTY.
  - On the first rising clk edge with rst_n high, s_ready goes 1.
- Transfers: an input transfer occurs on an edge where s_valid&s_ready. An output transfer occurs on an edge where m_valid&m_ready.
- Latency: a word accepted at edge N appears on m_data with m_valid=1 after edge N (visible in cycle N+1) when the block was EMPTY.
- No combinational path from any input to any output.
- State machine (3 states):
  - EMPTY (m_valid=0, s_ready=1, level=0):
    - s_valid: m_data<=s_data, go BUSY.
    - Otherwise: stay.
  - BUSY (m_valid=1, s_ready=1, level=1):
    - s_valid & m_ready: m_data<=s_data, stay BUSY.
    - s_valid & !m_ready: skid<=s_data, s_ready<=0, go FULL.
    - !s_valid & m_ready: m_valid<=0, go EMPTY.
    - Neither: hold.
  - FULL (m_valid=1, s_ready=0, level=2):
    - m_ready: m_data<=skid, s_ready<=1, go BUSY.
    - Otherwise: hold. s_valid is ignored (not accepted) while s_ready=0.
- Ordering: strict FIFO. A word in the skid register is never bypassed by a newer word.
- Stability:
  - While m_valid=1 and m_ready=0, m_data and m_valid do not change.
  - Upstream must hold s_data/s_valid stable while s_valid=1 and s_ready=0. The block does not check this.
- Unused encodings: an illegal state value returns to EMPTY on the next edge with m_valid=0, s_ready=1, level=0.
- Reset mid-operation: all held words are discarded. Outputs return to their reset values immediately. A subsequent downstream m_ready causes no transfer.
- No data modification: m_data is bit-exact s_data.

Decomposition:
- Shared package pipe_pkg:
  - state width constant PIPE_STATE_W=2
  - state encodings PIPE_EMPTY=2'b00, PIPE_BUSY=2'b01, PIPE_FULL=2'b10
  - occupancy width constant PIPE_LEVEL_W=2
- These constants are reused by later pipeline stages.
- No sub-module: the block is a single FSM plus two data registers.

Test Plan:
- Reset/startup: hold rst_n=0 for 3 cycles, then release. Required: m_valid=0, level=0 throughout reset; s_ready=0 during reset, 1 after the first edge with rst_n=1.
- Streaming: m_ready=1, send 0x00000001..0x00000010 on consecutive cycles. Required: m_data shows the same 16 values in order, each one cycle later; level never exceeds 1; no gaps.
- Backpressure fill: send 0xAAAA0001 and 0xAAAA0002 with m_ready=0. Required: level=2, s_ready=0, m_data=0xAAAA0001 stable. A third word 0xAAAA0003 held with s_valid is not accepted. Then assert m_ready: outputs are 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 in order.
- Random stall: 1000 random words, s_valid and m_ready each random at 50%. Required: the output sequence equals the input sequence exactly; m_data stable whenever m_valid&!m_ready.
- Async reset mid-operation: with level=2, drop rst_n between clock edges. Required: m_valid=0, s_ready=0, level=0 immediately (before the next edge); no stale word emitted after release.
- Width check: instantiate with DATA_WIDTH=1 and DATA_WIDTH=64, then repeat the backpressure-fill scenario. Required: correct order and values; for 64-bit use 0xFFFF0000FFFF0000 and 0x0123456789ABCDEF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage constants: FSM state encodings and occupancy width.
// Reused by every valid/ready stage in the datapath.
package pipe_pkg;

    localparam int PIPE_STATE_W = 2;
    localparam int PIPE_LEVEL_W = 2;

    typedef logic [PIPE_STATE_W-1:0] pipe_state_t;
    typedef logic [PIPE_LEVEL_W-1:0] pipe_level_t;

    localparam pipe_state_t PIPE_EMPTY = 2'b00;
    localparam pipe_state_t PIPE_BUSY  = 2'b01;
    localparam pipe_state_t PIPE_FULL  = 2'b10;

    // Occupancy implied by a state; unused encodings read as empty.
    function automatic pipe_level_t pipe_level(input pipe_state_t s);
        pipe_level_t lv;
        lv = 2'd0;
        case (s)
            PIPE_BUSY: lv = 2'd1;
            PIPE_FULL: lv = 2'd2;
            default:   lv = 2'd0;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry registered valid/ready stage ahead of the bitwise inverter.
// Every output is a flop, so no input reaches an output combinationally.
module skid_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [PIPE_LEVEL_W-1:0] level
);

    pipe_state_t           state;
    pipe_state_t           state_next;
    logic [DATA_WIDTH-1:0] skid;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  load_head;
    logic                  load_skid;
    logic                  pop_skid;
    logic                  m_valid_d;
    logic                  s_ready_d;
    pipe_level_t           level_d;

    assign in_xfer  = s_valid & s_ready;
    assign out_xfer = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PIPE_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_skid  = 1'b0;
        pop_skid   = 1'b0;
        case (state)
            PIPE_EMPTY: begin
                if (in_xfer) begin
                    load_head  = 1'b1;
                    state_next = PIPE_BUSY;
                end
            end
            PIPE_BUSY: begin
                if (in_xfer && out_xfer) begin
                    load_head = 1'b1;
                end else if (in_xfer) begin
                    load_skid  = 1'b1;
                    state_next = PIPE_FULL;
                end else if (out_xfer) begin
                    state_next = PIPE_EMPTY;
                end
            end
            PIPE_FULL: begin
                // s_ready is low here, so only the skid word can move.
                if (out_xfer) begin
                    pop_skid   = 1'b1;
                    state_next = PIPE_BUSY;
                end
            end
            default: begin
                state_next = PIPE_EMPTY;
            end
        endcase
    end

    // Outputs are decoded from the next state and then registered.
    always_comb begin
        m_valid_d = 1'b0;
        s_ready_d = 1'b1;
        level_d   = pipe_level(state_next);
        case (state_next)
            PIPE_BUSY: begin
                m_valid_d = 1'b1;
                s_ready_d = 1'b1;
            end
            PIPE_FULL: begin
                m_valid_d = 1'b1;
                s_ready_d = 1'b0;
            end
            default: begin
                m_valid_d = 1'b0;
                s_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_ready <= 1'b0;
            level   <= '0;
        end else begin
            m_valid <= m_valid_d;
            s_ready <= s_ready_d;
            level   <= level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= '0;
        end else if (load_head) begin
            m_data <= s_data;
        end else if (pop_skid) begin
            m_data <= skid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid <= '0;
        end else if (load_skid) begin
            skid <= s_data;
        end
    end

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and random-stall bench for skid_buffer at widths 32, 1 and 64.
// Each comparison is an immediate assertion that bumps the pass/fail tally.
module tb_skid_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        a_sv, a_sr, a_mv, a_mr;
    logic [31:0] a_sd, a_md;
    logic [1:0]  a_lv;

    logic        b_sv, b_sr, b_mv, b_mr;
    logic [0:0]  b_sd, b_md;
    logic [1:0]  b_lv;

    logic        c_sv, c_sr, c_mv, c_mr;
    logic [63:0] c_sd, c_md;
    logic [1:0]  c_lv;

    int passed = 0;
    int checks = 0;
    int fails  = 0;

    skid_buffer u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
        .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md),
        .level(a_lv)
    );

    skid_buffer #(.DATA_WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
        .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md),
        .level(b_lv)
    );

    skid_buffer #(.DATA_WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(c_sv), .s_ready(c_sr), .s_data(c_sd),
        .m_valid(c_mv), .m_ready(c_mr), .m_data(c_md),
        .level(c_lv)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_word;
    logic [31:0] stall_data;
    logic        stalled;
    logic        hold;
    int          sent;
    int          recv;

    initial begin
        rst_n = 1'b0;
        a_sv = 0; a_mr = 0; a_sd = '0;
        b_sv = 0; b_mr = 0; b_sd = '0;
        c_sv = 0; c_mr = 0; c_sd = '0;

        // reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_m_valid", a_mv, 0);
            chk("rst_level", a_lv, 0);
            chk("rst_s_ready", a_sr, 0);
        end
        chk("rst_m_data", a_md, 0);
        rst_n = 1'b1;
        step();
        chk("start_s_ready", a_sr, 1);
        chk("start_m_valid", a_mv, 0);
        chk("start_level", a_lv, 0);
        chk("start_s_ready_w1", b_sr, 1);
        chk("start_s_ready_w64", c_sr, 1);

        // streaming at full rate
        a_mr = 1'b1;
        a_sv = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_sd = 32'(i);
            step();
            chk("stream_data", a_md, 64'(i));
            chk("stream_valid", a_mv, 1);
            chk("stream_level", a_lv, 1);
        end
        a_sv = 1'b0;
        step();
        chk("stream_drain_valid", a_mv, 0);
        chk("stream_drain_level", a_lv, 0);

        // backpressure fill
        a_mr = 1'b0;
        a_sv = 1'b1;
        a_sd = 32'hAAAA0001;
        step();
        chk("bp_first_data", a_md, 32'hAAAA0001);
        chk("bp_first_level", a_lv, 1);
        a_sd = 32'hAAAA0002;
        step();
        chk("bp_full_level", a_lv, 2);
        chk("bp_full_s_ready", a_sr, 0);
        chk("bp_full_data", a_md, 32'hAAAA0001);
        a_sd = 32'hAAAA0003;
        step();
        step();
        chk("bp_hold_level", a_lv, 2);
        chk("bp_hold_data", a_md, 32'hAAAA0001);
        chk("bp_hold_valid", a_mv, 1);
        chk("bp_hold_s_ready", a_sr, 0);
        a_mr = 1'b1;
        step();
        chk("bp_out2_data", a_md, 32'hAAAA0002);
        chk("bp_out2_level", a_lv, 1);
        step();
        chk("bp_out3_data", a_md, 32'hAAAA0003);
        chk("bp_out3_level", a_lv, 1);
        a_sv = 1'b0;
        step();
        chk("bp_empty_valid", a_mv, 0);
        chk("bp_empty_level", a_lv, 0);

        // random stalls on both sides
        sent = 0;
        recv = 0;
        hold = 1'b0;
        a_sv = 1'b0;
        for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
            if (!hold) begin
                if (sent < 1000 && $urandom_range(1, 0) == 1) begin
                    a_sv = 1'b1;
                    a_sd = $urandom;
                end else begin
                    a_sv = 1'b0;
                end
            end
            a_mr = 1'($urandom_range(1, 0));
            if (a_mv && a_mr) begin
                if (q.size() == 0) begin
                    chk("rand_extra_word", 1, 0);
                end else begin
                    exp_word = q.pop_front();
                    chk("rand_order", a_md, exp_word);
                end
                recv++;
            end
            if (a_sv && a_sr) begin
                q.push_back(a_sd);
                sent++;
                hold = 1'b0;
            end else begin
                hold = a_sv;
            end
            stalled    = a_mv && !a_mr;
            stall_data = a_md;
            step();
            if (stalled) begin
                chk("rand_stall_data", a_md, stall_data);
                chk("rand_stall_valid", a_mv, 1);
            end
        end
        chk("rand_recv_count", recv, 1000);
        chk("rand_sent_count", sent, 1000);
        a_sv = 1'b0;
        a_mr = 1'b1;
        step();
        step();
        chk("rand_final_valid", a_mv, 0);

        // async reset while full
        a_mr = 1'b0;
        a_sv = 1'b1;
        a_sd = 32'h11111111;
        step();
        a_sd = 32'h22222222;
        step();
        chk("ar_pre_level", a_lv, 2);
        a_sv = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_m_valid", a_mv, 0);
        chk("ar_s_ready", a_sr, 0);
        chk("ar_level", a_lv, 0);
        chk("ar_m_data", a_md, 0);
        step();
        rst_n = 1'b1;
        a_mr = 1'b1;
        step();
        chk("ar_post_valid", a_mv, 0);
        chk("ar_post_s_ready", a_sr, 1);
        chk("ar_post_level", a_lv, 0);
        step();
        chk("ar_no_stale", a_mv, 0);
        a_mr = 1'b0;

        // backpressure fill at widths 1 and 64
        b_mr = 1'b0;
        c_mr = 1'b0;
        b_sv = 1'b1;
        c_sv = 1'b1;
        b_sd = 1'b1;
        c_sd = 64'hFFFF0000FFFF0000;
        step();
        chk("w1_first", b_md, 1);
        chk("w64_first", c_md, 64'hFFFF0000FFFF0000);
        b_sd = 1'b0;
        c_sd = 64'h0123456789ABCDEF;
        step();
        chk("w1_full_level", b_lv, 2);
        chk("w64_full_level", c_lv, 2);
        chk("w1_full_s_ready", b_sr, 0);
        chk("w64_full_s_ready", c_sr, 0);
        b_sd = 1'b1;
        c_sd = 64'hDEADBEEFCAFEF00D;
        step();
        chk("w1_hold_data", b_md, 1);
        chk("w64_hold_data", c_md, 64'hFFFF0000FFFF0000);
        b_mr = 1'b1;
        c_mr = 1'b1;
        step();
        chk("w1_out2", b_md, 0);
        chk("w64_out2", c_md, 64'h0123456789ABCDEF);
        step();
        chk("w1_out3", b_md, 1);
        chk("w64_out3", c_md, 64'hDEADBEEFCAFEF00D);
        b_sv = 1'b0;
        c_sv = 1'b0;
        step();
        chk("w1_empty", b_mv, 0);
        chk("w64_empty", c_mv, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
